// File: rtl/jt08_adpcm_mix_pkg.sv
// Shared definitions for the ADPCM channel mixer.
//   ATT_W   : width of one per-channel attenuation field
//   att_t   : one attenuation field
//   aw_of() : accumulator width for a given input width and channel count
//   sat_to(): clip a value to the signed range of an ow-bit word
package jt08_adpcm_mix_pkg;

  localparam int ATT_W = 3;

  typedef logic [ATT_W-1:0] att_t;

  // One guard bit above the CH-fold growth so a full frame never wraps.
  function automatic int aw_of(input int iw, input int ch);
    return iw + $clog2(ch) + 1;
  endfunction

  function automatic longint sat_to(input longint v, input int ow);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -(longint'(1) <<< (ow - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/jt08_adpcm_mix_if.sv
// Channel-sample bus between the ADPCM decoders and the mixer.
//   master: drives cen, cur_ch, match, en_sum, en_ch, att, pcm_in, clr_ovf;
//           receives pcm_out, out_valid, ovf
//   slave : the mixer side, the reverse directions
interface jt08_adpcm_mix_if #(
  parameter int CH = 6,
  parameter int IW = 16,
  parameter int OW = 16
);
  import jt08_adpcm_mix_pkg::*;

  logic                  cen;
  logic [CH-1:0]         cur_ch;
  logic                  match;
  logic                  en_sum;
  logic [CH-1:0]         en_ch;
  logic [ATT_W*CH-1:0]   att;
  logic signed [IW-1:0]  pcm_in;
  logic                  clr_ovf;
  logic signed [OW-1:0]  pcm_out;
  logic                  out_valid;
  logic                  ovf;

  modport master (
    output cen, cur_ch, match, en_sum, en_ch, att, pcm_in, clr_ovf,
    input  pcm_out, out_valid, ovf
  );

  modport slave (
    input  cen, cur_ch, match, en_sum, en_ch, att, pcm_in, clr_ovf,
    output pcm_out, out_valid, ovf
  );

endinterface

// File: rtl/jt08_adpcm_mix_ramp.sv
// Linear interpolation of the mixer output towards each new frame value.
//   clk, rst_n : clock, async active-low reset
//   cen_i      : clock enable, ramp steps only on enabled edges
//   load_i     : new frame value available on tgt_i (already qualified by cen)
//   tgt_i      : saturated frame value
//   pcm_o      : interpolated output
module jt08_adpcm_mix_ramp #(
  parameter int OW   = 16,
  parameter int ILOG = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen_i,
  input  logic                 load_i,
  input  logic signed [OW-1:0] tgt_i,
  output logic signed [OW-1:0] pcm_o
);

  localparam int             CW       = ILOG + 1;
  localparam logic [CW-1:0]  CNT_FULL = CW'(1 << ILOG);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic signed [OW-1:0] tgt_q, tgt_d;
  logic signed [OW-1:0] out_q, out_d;
  logic signed [OW:0]   delta_q, delta_d;
  logic signed [OW:0]   diff;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Step is taken from the current output, so a frame arriving mid-ramp
  // continues smoothly from wherever the ramp has got to.
  assign diff = $signed({tgt_i[OW-1], tgt_i}) - $signed({out_q[OW-1], out_q});

  always_comb begin
    tgt_d   = tgt_q;
    out_d   = out_q;
    delta_d = delta_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      tgt_d   = tgt_i;
      delta_d = diff >>> ILOG;
      cnt_d   = CNT_FULL;
    end else if (cen_i && (cnt_q > CNT_ONE)) begin
      out_d = OW'($signed({out_q[OW-1], out_q}) + delta_q);
      cnt_d = cnt_q - CNT_ONE;
    end else if (cen_i && (cnt_q == CNT_ONE)) begin
      // Last step lands on the target exactly, absorbing shift rounding.
      out_d = tgt_q;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q   <= '0;
      out_q   <= '0;
      delta_q <= '0;
      cnt_q   <= '0;
    end else begin
      tgt_q   <= tgt_d;
      out_q   <= out_d;
      delta_q <= delta_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pcm_o = out_q;

endmodule

// File: rtl/jt08_adpcm_mix.sv
// Time-multiplexed ADPCM channel mixer: sums one sample per channel over a
// rotation, applies per-channel mute/attenuation, saturates each frame and
// either holds it or ramps to it.
//   clk, rst_n : clock, async active-low reset
//   bus        : jt08_adpcm_mix_if slave (channel samples in, mixed output,
//                out_valid pulse and sticky ovf out)
module jt08_adpcm_mix
  import jt08_adpcm_mix_pkg::*;
#(
  parameter int CH     = 6,
  parameter int IW     = 16,
  parameter int OW     = 16,
  parameter int INTERP = 0,
  parameter int ILOG   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  jt08_adpcm_mix_if.slave  bus
);

  localparam int AW = aw_of(IW, CH);

  logic                 onehot;
  logic                 ch_en;
  att_t                 att_sel;
  logic signed [AW-1:0] pcm_ext;
  logic signed [AW-1:0] term;
  logic                 step;
  logic                 frame;
  longint               fsum_sat;
  logic                 clip;
  logic signed [OW-1:0] sat_out;

  logic signed [AW-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;

  // Malformed channel strobes (none or several bits) are ignored outright.
  assign onehot = (bus.cur_ch != '0) && ((bus.cur_ch & (bus.cur_ch - CH'(1))) == '0);
  assign ch_en  = bus.en_sum & (|(bus.en_ch & bus.cur_ch));

  always_comb begin
    att_sel = '0;
    for (int i = 0; i < CH; i++) begin
      if (bus.cur_ch[i]) att_sel = att_sel | bus.att[ATT_W*i +: ATT_W];
    end
  end

  assign pcm_ext = {{(AW-IW){bus.pcm_in[IW-1]}}, bus.pcm_in};

  always_comb begin
    term = '0;
    if (ch_en) term = pcm_ext >>> att_sel;
  end

  assign step  = bus.cen & bus.match & onehot;
  assign frame = step & bus.cur_ch[0];

  // The completing frame is the accumulator before this edge's term.
  assign fsum_sat = sat_to(longint'(acc_q), OW);
  assign clip     = (fsum_sat != longint'(acc_q));
  assign sat_out  = OW'(fsum_sat);

  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    valid_d = frame;
    if (step) acc_d = bus.cur_ch[0] ? term : acc_q + term;
    if (bus.clr_ovf) ovf_d = 1'b0;
    if (frame && clip) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.ovf       = ovf_q;

  generate
    if (INTERP == 0) begin : g_hold
      logic signed [OW-1:0] out_q, out_d;

      always_comb begin
        out_d = out_q;
        if (frame) out_d = sat_out;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
      end

      assign bus.pcm_out = out_q;
    end else begin : g_ramp
      jt08_adpcm_mix_ramp #(
        .OW   (OW),
        .ILOG (ILOG)
      ) u_ramp (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen_i  (bus.cen),
        .load_i (frame),
        .tgt_i  (sat_out),
        .pcm_o  (bus.pcm_out)
      );
    end
  endgenerate

endmodule
